// File: rtl/seq_pkg.sv
// ---------------------------------------------------------------------------
// seq_pkg
// Shared definitions for the 1011 sequence detector:
//   PATTERN      - the serial pattern being tracked, first bit sent is MSB
//   det_state_e  - detector FSM encoding (how much of 1011 has been seen)
//   trk_state_e  - lock tracker FSM encoding
// ---------------------------------------------------------------------------
package seq_pkg;

    localparam logic [3:0] PATTERN = 4'b1011;

    typedef enum logic [1:0] {
        DET_IDLE   = 2'd0,
        DET_GOT1   = 2'd1,
        DET_GOT10  = 2'd2,
        DET_GOT101 = 2'd3
    } det_state_e;

    typedef enum logic [1:0] {
        TRK_HUNT    = 2'd0,
        TRK_CONFIRM = 2'd1,
        TRK_LOCKED  = 2'd2
    } trk_state_e;

endpackage

// File: rtl/sequence_1011_detector_if.sv
// ---------------------------------------------------------------------------
// sequence_1011_detector_if
// Signal bundle between a serial bit source and the 1011 detector.
//
// Handshake: valid-only, there is no ready. A bit is taken on every rising
// edge where data_valid=1 and clear=0; the receiver can always accept. clear
// has priority over data_valid, and the data bit of a clearing cycle is lost.
//
// Signals:
//   data_in, data_valid, clear          - source -> detector
//   match, in_sync                      - detector status
//   match_count, error_count            - saturating event counters
//   det_state, trk_state                - FSM state for observation
// Modports: master (bit source / monitor), slave (detector).
// ---------------------------------------------------------------------------
interface sequence_1011_detector_if #(
    parameter int CNT_W = 8
);
    import seq_pkg::*;

    logic             data_in;
    logic             data_valid;
    logic             clear;
    logic             match;
    logic             in_sync;
    logic [CNT_W-1:0] match_count;
    logic [CNT_W-1:0] error_count;
    det_state_e       det_state;
    trk_state_e       trk_state;

    modport master (
        output data_in, data_valid, clear,
        input  match, in_sync, match_count, error_count, det_state, trk_state
    );

    modport slave (
        input  data_in, data_valid, clear,
        output match, in_sync, match_count, error_count, det_state, trk_state
    );

endinterface

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Event counter that sticks at all-ones instead of wrapping.
// Ports:
//   clk, reset_n - clock, asynchronous active-low reset
//   inc          - count one event this cycle
//   clr          - synchronous clear to zero (wins over inc)
//   count        - current count
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] MAX = '1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != MAX)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/sequence_1011_detector.sv
// ---------------------------------------------------------------------------
// sequence_1011_detector
// Receive-side checker for a serial 1011 stream. Flags every (overlapping)
// occurrence of 1011 and tracks whether matches arrive exactly every four
// accepted bits, counting matches and loss-of-lock events.
// Ports:
//   clk      - rising-edge clock
//   reset_n  - asynchronous active-low reset; all outputs 0 while low
//   bus      - slave side of sequence_1011_detector_if (data in, status out)
// ---------------------------------------------------------------------------
module sequence_1011_detector
    import seq_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    sequence_1011_detector_if.slave       bus
);

    det_state_e       det_state, det_next;
    trk_state_e       trk_state, trk_next;
    logic [1:0]       phase, phase_next;
    logic             match_q;
    logic             accept;
    logic             match_now;
    logic             fourth;
    logic             err_inc;
    logic [CNT_W-1:0] match_count;
    logic [CNT_W-1:0] error_count;

    assign accept    = bus.data_valid && !bus.clear;
    // Only GOT101 followed by the last pattern bit completes a match.
    assign match_now = accept && (det_state == DET_GOT101) && (bus.data_in == PATTERN[0]);
    // phase counts accepted bits since the last match; 3 means this bit is the 4th.
    assign fourth    = (phase == 2'd3);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            det_state <= DET_IDLE;
            trk_state <= TRK_HUNT;
            phase     <= 2'd0;
            match_q   <= 1'b0;
        end else begin
            det_state <= det_next;
            trk_state <= trk_next;
            phase     <= phase_next;
            match_q   <= match_now;
        end
    end

    // Detector: longest suffix of the accepted stream that is a prefix of 1011.
    always_comb begin
        det_next = det_state;
        if (bus.clear) begin
            det_next = DET_IDLE;
        end else if (accept) begin
            case (det_state)
                DET_IDLE:   det_next = bus.data_in ? DET_GOT1   : DET_IDLE;
                DET_GOT1:   det_next = bus.data_in ? DET_GOT1   : DET_GOT10;
                DET_GOT10:  det_next = bus.data_in ? DET_GOT101 : DET_IDLE;
                // After a match the trailing 1 starts the next candidate.
                DET_GOT101: det_next = bus.data_in ? DET_GOT1   : DET_GOT10;
                default:    det_next = DET_IDLE;
            endcase
        end
    end

    // Tracker: locks after two matches exactly four bits apart.
    always_comb begin
        trk_next   = trk_state;
        phase_next = phase;
        err_inc    = 1'b0;
        if (bus.clear) begin
            trk_next   = TRK_HUNT;
            phase_next = 2'd0;
        end else if (accept) begin
            phase_next = phase + 2'd1;
            case (trk_state)
                TRK_HUNT: begin
                    if (match_now) begin
                        trk_next   = TRK_CONFIRM;
                        phase_next = 2'd0;
                    end
                end
                TRK_CONFIRM: begin
                    if (match_now) begin
                        trk_next   = fourth ? TRK_LOCKED : TRK_CONFIRM;
                        phase_next = 2'd0;
                    end else if (fourth) begin
                        trk_next = TRK_HUNT;
                    end
                end
                TRK_LOCKED: begin
                    if (match_now) begin
                        phase_next = 2'd0;
                        if (!fourth) begin
                            trk_next = TRK_CONFIRM;
                            err_inc  = 1'b1;
                        end
                    end else if (fourth) begin
                        trk_next = TRK_HUNT;
                        err_inc  = 1'b1;
                    end
                end
                default: begin
                    trk_next   = TRK_HUNT;
                    phase_next = 2'd0;
                end
            endcase
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_match_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (match_now),
        .clr     (bus.clear),
        .count   (match_count)
    );

    sat_counter #(.WIDTH(CNT_W)) u_error_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (err_inc),
        .clr     (bus.clear),
        .count   (error_count)
    );

    assign bus.match       = match_q;
    assign bus.in_sync     = (trk_state == TRK_LOCKED);
    assign bus.match_count = match_count;
    assign bus.error_count = error_count;
    assign bus.det_state   = det_state;
    assign bus.trk_state   = trk_state;

endmodule

// File: tb/tb_sequence_1011_detector.sv
// ---------------------------------------------------------------------------
// tb_sequence_1011_detector
// Self-checking bench for sequence_1011_detector with 3-bit counters.
// ---------------------------------------------------------------------------
module tb_sequence_1011_detector;

    localparam int CNT_W = 3;
    localparam int EXP_W = 2 + 2 * CNT_W;
    localparam int CMAX  = (1 << CNT_W) - 1;

    typedef struct {
        logic             d;
        logic             v;
        logic             c;
        logic             m;
        logic             s;
        logic [CNT_W-1:0] mc;
        logic [CNT_W-1:0] ec;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    sequence_1011_detector_if #(.CNT_W(CNT_W)) bus ();

    sequence_1011_detector #(.CNT_W(CNT_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // ---------------- scoreboard / model ----------------
    int               checks = 0;
    int               errors = 0;
    logic [EXP_W-1:0] exp_q[$];

    logic [3:0] m_hist;
    int         m_trk;   // 0 hunt, 1 confirm, 2 locked
    int         m_gap;   // accepted bits since last match
    int         m_mc;
    int         m_ec;
    logic       m_match;
    logic [3:0] pat;

    vec_t vecs[12];

    task automatic check(input string name, input logic [EXP_W-1:0] act, input logic [EXP_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got match=%b sync=%b mc=%0d ec=%0d, want match=%b sync=%b mc=%0d ec=%0d",
                     name, act[EXP_W-1], act[EXP_W-2], act[2*CNT_W-1:CNT_W], act[CNT_W-1:0],
                     exp[EXP_W-1], exp[EXP_W-2], exp[2*CNT_W-1:CNT_W], exp[CNT_W-1:0]);
        end
    endtask

    function automatic logic [EXP_W-1:0] observed();
        return {bus.match, bus.in_sync, bus.match_count, bus.error_count};
    endfunction

    task automatic model_reset();
        m_hist  = 4'b0000;
        m_trk   = 0;
        m_gap   = 0;
        m_mc    = 0;
        m_ec    = 0;
        m_match = 1'b0;
    endtask

    task automatic model_update(input logic d, input logic v, input logic c);
        logic mm;
        if (c) begin
            model_reset();
        end else if (v) begin
            m_hist  = {m_hist[2:0], d};
            mm      = (m_hist == 4'b1011);
            m_match = mm;
            m_gap++;
            if (mm) begin
                if (m_mc < CMAX) m_mc++;
                if (m_trk == 0) begin
                    m_trk = 1;
                end else if (m_trk == 1) begin
                    m_trk = (m_gap == 4) ? 2 : 1;
                end else if (m_gap != 4) begin
                    m_trk = 1;
                    if (m_ec < CMAX) m_ec++;
                end
                m_gap = 0;
            end else if (m_gap == 4) begin
                if (m_trk == 2 && m_ec < CMAX) m_ec++;
                m_trk = 0;
                m_gap = 0;
            end
        end else begin
            m_match = 1'b0;
        end
    endtask

    function automatic logic [EXP_W-1:0] model_exp();
        return {m_match, (m_trk == 2), CNT_W'(m_mc), CNT_W'(m_ec)};
    endfunction

    // ---------------- driver tasks ----------------
    // Drive one cycle, then compare against the oldest queued expectation.
    task automatic apply(input logic d, input logic v, input logic c, input string name);
        logic [EXP_W-1:0] e;
        bus.data_in    = d;
        bus.data_valid = v;
        bus.clear      = c;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: got empty expected queue, want one entry", name);
        end else begin
            e = exp_q.pop_front();
            check(name, observed(), e);
        end
    endtask

    task automatic step(input logic d, input logic v, input logic c, input string name);
        model_update(d, v, c);
        exp_q.push_back(model_exp());
        apply(d, v, c, name);
    endtask

    task automatic send_pattern(input int nbits, input string name);
        for (int k = 0; k < nbits; k++) begin
            step(pat[3 - (k % 4)], 1'b1, 1'b0, name);
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        pat            = 4'b1011;
        reset_n        = 1'b0;
        bus.data_in    = 1'b0;
        bus.data_valid = 1'b0;
        bus.clear      = 1'b0;
        model_reset();

        vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd1, 3'd0};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 3'd0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 3'd0};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 3'd0};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'd2, 3'd0};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd2, 3'd0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd2, 3'd0};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd2, 3'd0};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'd3, 3'd0};

        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", observed(), '0);
        reset_n = 1'b1;

        // Clean stream from reset: table of hand-computed expectations.
        for (int i = 0; i < 12; i++) begin
            model_update(vecs[i].d, vecs[i].v, vecs[i].c);
            exp_q.push_back({vecs[i].m, vecs[i].s, vecs[i].mc, vecs[i].ec});
            apply(vecs[i].d, vecs[i].v, vecs[i].c, $sformatf("table_bit%0d", i + 1));
        end

        // Lock loss: bit 12 forced to 0, then clean stream to bit 20.
        step(1'b0, 1'b0, 1'b1, "clear_before_error");
        send_pattern(11, "err_prefix");
        step(1'b0, 1'b1, 1'b0, "err_bit12");
        check("err_bit12_const", observed(), {1'b0, 1'b0, 3'd2, 3'd1});
        for (int k = 12; k < 20; k++) begin
            step(pat[3 - (k % 4)], 1'b1, 1'b0, $sformatf("relock_bit%0d", k + 1));
        end
        check("relock_bit20_const", observed(), {1'b1, 1'b1, 3'd4, 3'd1});

        // Overlap: 1,0,1,1,0,1,1 -> matches after bits 4 and 7, no lock.
        step(1'b0, 1'b0, 1'b1, "clear_before_overlap");
        step(1'b1, 1'b1, 1'b0, "ovl1");
        step(1'b0, 1'b1, 1'b0, "ovl2");
        step(1'b1, 1'b1, 1'b0, "ovl3");
        step(1'b1, 1'b1, 1'b0, "ovl4");
        step(1'b0, 1'b1, 1'b0, "ovl5");
        step(1'b1, 1'b1, 1'b0, "ovl6");
        step(1'b1, 1'b1, 1'b0, "ovl7");
        check("ovl7_const", observed(), {1'b1, 1'b0, 3'd2, 3'd0});

        // data_valid gap of 5 cycles mid-period while locked.
        step(1'b0, 1'b0, 1'b1, "clear_before_gap");
        send_pattern(10, "gap_prefix");
        for (int g = 0; g < 5; g++) begin
            step(1'($urandom_range(0, 1)), 1'b0, 1'b0, "gap_idle");
        end
        step(1'b1, 1'b1, 1'b0, "gap_bit11");
        step(1'b1, 1'b1, 1'b0, "gap_bit12");
        check("gap_bit12_const", observed(), {1'b1, 1'b1, 3'd3, 3'd0});

        // Saturation: 10 matches with 3-bit counters, then one-cycle clear.
        step(1'b0, 1'b0, 1'b1, "clear_before_sat");
        send_pattern(40, "sat_stream");
        check("sat_const", observed(), {1'b1, 1'b1, 3'd7, 3'd0});
        step(1'b1, 1'b1, 1'b1, "sat_clear");
        check("sat_clear_const", observed(), '0);

        // Asynchronous reset while locked, no clock edge involved.
        send_pattern(8, "pre_reset_lock");
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_outputs", observed(), '0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        send_pattern(7, "post_reset_hunt");
        check("post_reset_bit7_const", observed(), {1'b0, 1'b0, 3'd1, 3'd0});
        send_pattern(1, "post_reset_bit8");
        check("post_reset_bit8_const", observed(), {1'b1, 1'b1, 3'd2, 3'd0});

        // Mostly-pattern stream with random corruption, gaps and clears.
        for (int k = 0; k < 300; k++) begin
            logic d;
            logic v;
            logic c;
            d = ($urandom_range(0, 11) == 0) ? 1'($urandom_range(0, 1)) : pat[3 - (k % 4)];
            v = ($urandom_range(0, 4) != 0);
            c = ($urandom_range(0, 60) == 0);
            step(d, v, c, "random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sequence_1011_detector.md
# sequence_1011_detector

Serial receive-side checker for the 1011 pattern stream driven by the team's sequence generator. It samples one bit per qualified clock, flags every occurrence of 1011 (overlapping allowed), and tracks whether the stream is a clean period-4 repetition. It also keeps saturating counts of matches and loss-of-lock events. It sits at the far end of the serial link, alongside the generator in loopback benches and in link-health monitoring.

## Interface
- CNT_W, default 8: width of both event counters.

- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous reset, active-low.
- data_in  input  1  serial data bit, sampled only when data_valid=1.
- data_valid  input  1  qualifies data_in this cycle.
- clear  input  1  synchronous clear of FSMs and counters.
- match  output  1  one-cycle pulse: the last accepted bit completed 1011.
- in_sync  output  1  level: stream locked to period-4 pattern.
- match_count  output  CNT_W  saturating count of match pulses.
- error_count  output  CNT_W  saturating count of loss-of-lock events.

## Operation
- Accepted bit: a rising edge with data_valid=1, clear=0, reset_n=1. No other edge changes the FSM or counters, except that match returns to 0.
- Detector FSM, advanced on accepted bits only. States and transitions (bit 0 / bit 1):
  - IDLE: 0→IDLE, 1→GOT1.
  - GOT1: 0→GOT10, 1→GOT1.
  - GOT10: 0→IDLE, 1→GOT101.
  - GOT101: 0→GOT10, 1→GOT1 with match (overlap retained).
- Tracker FSM, states HUNT / CONFIRM / LOCKED, with a 2-bit phase counter of accepted bits since the last match:
  - HUNT: on match → CONFIRM, phase=0.
  - CONFIRM:
    - Match on the 4th accepted bit after the previous match → LOCKED.
    - Match earlier → stay in CONFIRM, phase=0.
    - 4th bit with no match → HUNT.
  - LOCKED:
    - Match on the 4th bit → stay.
    - 4th bit with no match → HUNT, error_count+1.
    - Earlier match → CONFIRM, phase=0, error_count+1.
- in_sync = (tracker == LOCKED), registered.
- match_count increments on every match; error_count increments on every LOCKED exit. Both hold at 2^CNT_W−1 once reached, with no wrap.
- clear=1:
  - Detector → IDLE, tracker → HUNT, phase=0.
  - Both counters → 0, match=0, in_sync=0.
  - data_in that cycle is discarded. clear has priority over data_valid.
- reset_n low, asynchronously: all state as for clear, and all outputs 0 while low.

## Timing
- match asserts in the cycle after the edge that accepted the completing bit; it lasts exactly one cycle.
- in_sync, match_count and error_count update on that same edge. match_count reflects the new value while match is high.
- A steady generator stream starting from reset gives:
  - Matches on accepted bits 4, 8, 12, …
  - in_sync rising together with the second match pulse.
- data_valid low holds the whole state; gaps do not break lock.
- Reset release: the first edge with reset_n=1 may accept a bit.
- Latency: bit in → match/in_sync out is 1 cycle.

## Structure
- Shared package seq_pkg:
  - PATTERN = 4'b1011.
  - Detector state encoding (IDLE=0, GOT1=1, GOT10=2, GOT101=3).
  - Tracker state encoding (HUNT=0, CONFIRM=1, LOCKED=2).
- Sub-module sat_counter, parameterised by width, with ports inc, clr and count. It is instantiated twice, for match_count and error_count.
- Detector FSM, tracker FSM and output registers live in the top module.

## Test plan
- Reset, then a continuous 1011 stream for 12 accepted bits:
  - match pulses after bits 4, 8 and 12.
  - in_sync=1 from the bit-8 pulse onward.
  - match_count=3, error_count=0.
- Locked stream with bit 12 forced to 0, then a clean stream:
  - No match at bit 12; in_sync falls; error_count=1.
  - Next match at bit 16; in_sync high again after bit 20.
- Overlap input 1,0,1,1,0,1,1: match after bits 4 and 7; match_count=2; in_sync stays 0.
- Locked stream with data_valid low for 5 cycles mid-period: no match during the gap, in_sync stays 1, and the next match arrives on schedule after resumption.
- Bench with CNT_W=3 and 10 consecutive matches: match_count stops at 7. clear=1 for one cycle then gives both counters 0 and in_sync 0.
- reset_n pulled low while LOCKED, with no clock edge: all outputs 0 immediately. After release, a fresh stream needs 8 bits to relock.
